wb_ocm_slv: RTL and testbench

Wishbone classic slave that fronts a single-port on-chip memory (OCM) and terminates each transfer with ack, err or rty. It is the responder at the far end of the core bridge's Wishbone master port, serving instruction and data fetches from a fixed address window. Wait-state insertion is programmable by parameter, and a hold input forces retries.

---
 rtl/wb_ocm_slv.sv | 177 +++++++++++++++++
 tb/tb_wb_ocm_slv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_ocm_slv.sv
// Wishbone classic slave in front of a single-port on-chip memory with
// parameterised wait states, hold-driven retries and error responses.
module wb_ocm_slv #(
    parameter int              dw     = 32,
    parameter int              aw     = 32,
    parameter int              mem_aw = 10,
    parameter logic [aw-1:0]   BASE   = 32'h8000_0000,
    parameter int              WS     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic [aw-1:0]     wb_adr_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [dw-1:0]     wb_dat_i,
    input  logic [2:0]        wb_cti_i,
    input  logic [1:0]        wb_bte_i,
    input  logic              ocm_hold_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    output logic [dw-1:0]     wb_dat_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WS_LOAD = 4'((WS > 0) ? WS - 1 : 0);

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;
    logic                ack_reg, ack_next;
    logic                err_reg, err_next;
    logic                rty_reg, rty_next;
    logic                capture;
    logic                acc_en;

    logic [mem_aw-1:0]   idx_reg;
    logic                we_reg;
    logic [3:0]          sel_reg;
    logic [dw-1:0]       dat_reg;

    logic [mem_aw-1:0]   acc_idx;
    logic                acc_we;
    logic [3:0]          acc_sel;
    logic [dw-1:0]       acc_dat;
    logic                mem_wr;
    logic                mem_rd;
    logic [dw-1:0]       rd_word;

    logic                req;
    logic                in_window;
    logic                sel_legal;

    wire unused_bits = &{1'b0, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

    assign req       = wb_cyc_i & wb_stb_i;
    assign in_window = (wb_adr_i[aw-1:mem_aw+2] == BASE[aw-1:mem_aw+2]);

    always_comb begin
        sel_legal = 1'b0;
        case (wb_sel_i)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_legal = 1'b1;
            default:                            sel_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        rty_next   = 1'b0;
        capture    = 1'b0;
        acc_en     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    capture = 1'b1;
                    if (ocm_hold_i) begin
                        rty_next   = 1'b1;
                        state_next = RESP;
                    end else if (!in_window || !sel_legal) begin
                        err_next   = 1'b1;
                        state_next = RESP;
                    end else if (WS == 0) begin
                        acc_en     = 1'b1;
                        ack_next   = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = WS_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    acc_en     = 1'b1;
                    ack_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rty_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            rty_reg   <= rty_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg <= '0;
            we_reg  <= 1'b0;
            sel_reg <= 4'd0;
            dat_reg <= '0;
        end else if (capture) begin
            idx_reg <= wb_adr_i[mem_aw+1:2];
            we_reg  <= wb_we_i;
            sel_reg <= wb_sel_i;
            dat_reg <= wb_dat_i;
        end
    end

    // Zero-wait accesses happen on the sampling edge, so take the live bus.
    assign acc_idx = (state_reg == IDLE) ? wb_adr_i[mem_aw+1:2] : idx_reg;
    assign acc_we  = (state_reg == IDLE) ? wb_we_i  : we_reg;
    assign acc_sel = (state_reg == IDLE) ? wb_sel_i : sel_reg;
    assign acc_dat = (state_reg == IDLE) ? wb_dat_i : dat_reg;

    assign mem_wr = acc_en & acc_we & ~rst;
    assign mem_rd = acc_en & ~acc_we;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem [2**mem_aw];
        logic [7:0] rd_reg;

        always_ff @(posedge clk) begin
            if (mem_wr && acc_sel[gi])
                mem[acc_idx] <= acc_dat[gi*8 +: 8];
        end

        always_ff @(posedge clk) begin
            if (rst)
                rd_reg <= 8'h00;
            else if (mem_rd)
                rd_reg <= mem[acc_idx];
        end

        assign rd_word[gi*8 +: 8] = rd_reg;
    end

    assign wb_ack_o = ack_reg;
    assign wb_err_o = err_reg;
    assign wb_rty_o = rty_reg;
    assign wb_dat_o = rd_word;

endmodule

// File: tb/tb_wb_ocm_slv.sv
// Randomised bench for wb_ocm_slv: three instances (WS = 1, 3, 0) checked
// against a word-array memory model and the termination/latency rules.
module tb_wb_ocm_slv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  cyc_v = 3'b000;
    logic [2:0]  stb_v = 3'b000;
    logic [31:0] adr = 32'h0;
    logic        we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] dat = 32'h0;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;
    logic        hold = 1'b0;
    logic [2:0]  ack_v, err_v, rty_v;
    logic [31:0] dato_v [3];

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] model_mem  [3][1024];
    logic [31:0] model_dato [3];
    bit   [2:0]  prev_keep = 3'b000;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        wb_ocm_slv #(.WS((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .wb_cyc_i   (cyc_v[gi]),
            .wb_stb_i   (stb_v[gi]),
            .wb_adr_i   (adr),
            .wb_we_i    (we),
            .wb_sel_i   (sel),
            .wb_dat_i   (dat),
            .wb_cti_i   (cti),
            .wb_bte_i   (bte),
            .ocm_hold_i (hold),
            .wb_ack_o   (ack_v[gi]),
            .wb_err_o   (err_v[gi]),
            .wb_rty_o   (rty_v[gi]),
            .wb_dat_o   (dato_v[gi])
        );
    end

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 0);
    endfunction

    function automatic bit sel_ok(input logic [3:0] s);
        logic [3:0] legal [7];
        legal = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        foreach (legal[i]) if (legal[i] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic xfer(input int k, input logic [31:0] a, input logic w,
                        input logic [3:0] s, input logic [31:0] d,
                        input logic h, input bit keep);
        int         lat;
        int         lat_exp;
        int         idx;
        logic [2:0] term_exp;
        logic [2:0] term_got;
        logic [31:0] word;

        adr = a; we = w; sel = s; dat = d; hold = h;
        cyc_v[k] = 1'b1;
        stb_v[k] = 1'b1;

        idx = int'(a[11:2]);
        if (h)                          term_exp = 3'b001;
        else if (a[31:12] != 20'h80000) term_exp = 3'b010;
        else if (!sel_ok(s))            term_exp = 3'b010;
        else                            term_exp = 3'b100;
        lat_exp = ((term_exp == 3'b100) ? 1 + ws_of(k) : 1) + (prev_keep[k] ? 1 : 0);
        if (term_exp == 3'b100) begin
            if (w) begin
                word = model_mem[k][idx];
                for (int b = 0; b < 4; b++)
                    if (s[b]) word[b*8 +: 8] = d[b*8 +: 8];
                model_mem[k][idx] = word;
            end else begin
                model_dato[k] = model_mem[k][idx];
            end
        end

        lat = 0;
        for (int i = 1; i <= 24; i++) begin
            tick();
            if (ack_v[k] | err_v[k] | rty_v[k]) begin
                lat = i;
                break;
            end
        end
        term_got = {ack_v[k], err_v[k], rty_v[k]};
        check("term", 32'(term_got), 32'(term_exp));
        check("latency", lat, lat_exp);
        check("dat_o", dato_v[k], model_dato[k]);
        $display("xfer k=%0d adr=%h we=%0d sel=%b dat=%h hold=%0d term=%b lat=%0d dat_o=%h",
                 k, a, w, s, d, h, term_got, lat, dato_v[k]);

        prev_keep[k] = keep;
        if (!keep) begin
            cyc_v[k] = 1'b0;
            stb_v[k] = 1'b0;
            hold     = 1'b0;
            tick();
            check("idle_term", 32'({ack_v[k], err_v[k], rty_v[k]}), 32'h0);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        logic [3:0]  legal_tab [7];
        bit          keep;
        legal_tab = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

        for (int k = 0; k < 3; k++) model_dato[k] = 32'h0;

        // Power-on reset with idle bus
        repeat (3) tick();
        for (int k = 0; k < 3; k++) begin
            check("reset_term", 32'({ack_v[k], err_v[k], rty_v[k]}), 32'h0);
            check("reset_dat", dato_v[k], 32'h0);
        end
        rst = 1'b0;
        tick();

        // Give every word the bench uses a known value
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++)
                xfer(k, 32'h8000_0000 + 32'(i * 4), 1'b1, 4'hF, $urandom, 1'b0, 1'b0);

        // Reset lands on the edge where a WS=1 write would commit
        adr = 32'h8000_0000; we = 1'b1; sel = 4'hF; dat = 32'h5A5A_A5A5;
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            tick();
            check("rst_term", 32'({ack_v[0], err_v[0], rty_v[0]}), 32'h0);
            check("rst_dat", dato_v[0], 32'h0);
        end
        cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) model_dato[k] = 32'h0;
        tick();
        xfer(0, 32'h8000_0000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        // Write/read, byte lane, errors, retry on WS=1
        xfer(0, 32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0);
        xfer(0, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        check("read_back", dato_v[0], 32'hDEAD_BEEF);
        xfer(0, 32'h8000_0010, 1'b1, 4'b0100, 32'h1122_3344, 1'b0, 1'b0);
        xfer(0, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        check("byte_lane", dato_v[0], 32'hDE22_BEEF);
        xfer(0, 32'h8000_1000, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        xfer(0, 32'h8000_0010, 1'b1, 4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b0);
        xfer(0, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);
        check("no_err_write", dato_v[0], 32'hDE22_BEEF);
        xfer(0, 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1'b1, 1'b0);

        // Abort in WAIT on WS=3: strobe dropped while the counter is running
        adr = 32'h8000_0020; we = 1'b1; sel = 4'hF; dat = 32'hCAFE_F00D;
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
        repeat (2) tick();
        cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
        repeat (5) begin
            tick();
            check("abort_term", 32'({ack_v[1], err_v[1], rty_v[1]}), 32'h0);
        end
        xfer(1, 32'h8000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0);

        // WS=0 back-to-back reads with strobe held throughout
        for (int i = 0; i < 4; i++)
            xfer(2, 32'h8000_0000 + 32'(i * 4), 1'b0, 4'hF, 32'h0, 1'b0, i != 3);

        // Randomised traffic on every instance
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 30; t++) begin
                a = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a ^ 32'h0000_1000;
                if ($urandom_range(0, 1) == 1) s = legal_tab[$urandom_range(0, 6)];
                else                           s = 4'($urandom);
                keep = (t != 29) && ($urandom_range(0, 3) == 0);
                xfer(k, a, 1'($urandom), s, $urandom, $urandom_range(0, 7) == 0, keep);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
